// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: multiply/divide op encodings, control states,
// register-index width.
package cpu_pkg;

  localparam int unsigned REG_IDX_W = 3;

  localparam logic [1:0] MDU_MUL  = 2'b00;
  localparam logic [1:0] MDU_MULH = 2'b01;
  localparam logic [1:0] MDU_DIV  = 2'b10;
  localparam logic [1:0] MDU_MOD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Fixed-latency unsigned multiply/divide unit; one shared 2*WIDTH shift register
// serves shift-add multiply and restoring divide, chosen by the latched op.
module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [REG_IDX_W-1:0] dst,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_en,
  output logic [REG_IDX_W-1:0] wr_addr,
  output logic [WIDTH-1:0]     result,
  output logic                 div_by_zero
);

  localparam int unsigned AW = 2 * WIDTH;

  mdu_state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [AW-1:0]        r_acc, w_acc_nxt;
  logic [WIDTH-1:0]     r_a, w_a_nxt;
  logic [WIDTH-1:0]     r_b, w_b_nxt;
  logic [1:0]           r_op, w_op_nxt;
  logic [REG_IDX_W-1:0] r_dst, w_dst_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic [REG_IDX_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [WIDTH-1:0]     r_result, w_result_nxt;
  logic                 r_dbz, w_dbz_nxt;

  // Multiply step: conditionally add multiplicand into the high half, shift right.
  logic [WIDTH:0]  w_mul_sum;
  logic [AW-1:0]   w_mul_step;
  assign w_mul_sum  = {1'b0, r_acc[AW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : (WIDTH+1)'(0));
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide step: shift remainder/quotient left, subtract divisor when it fits.
  logic [WIDTH:0]  w_rem_sh;
  logic            w_fits;
  logic [AW-1:0]   w_div_step;
  assign w_rem_sh   = r_acc[AW-1:WIDTH-1];
  assign w_fits     = (w_rem_sh >= {1'b0, r_b});
  assign w_div_step = {(w_fits ? (w_rem_sh[WIDTH-1:0] - r_b) : w_rem_sh[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_fits};

  logic [AW-1:0]    w_step;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_final;
  assign w_step   = r_op[1] ? w_div_step : w_mul_step;
  assign w_b_zero = (r_b == '0);

  // Result extraction from the post-final-iteration register, with b=0 overrides.
  always_comb begin
    w_final = w_step[WIDTH-1:0];
    case (r_op)
      MDU_MUL:  w_final = w_step[WIDTH-1:0];
      MDU_MULH: w_final = w_step[AW-1:WIDTH];
      MDU_DIV:  w_final = w_b_zero ? {WIDTH{1'b1}} : w_step[WIDTH-1:0];
      MDU_MOD:  w_final = w_b_zero ? r_a : w_step[AW-1:WIDTH];
      default:  w_final = w_step[WIDTH-1:0];
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_acc_nxt     = r_acc;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_op_nxt      = r_op;
    w_dst_nxt     = r_dst;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_result_nxt  = r_result;
    w_dbz_nxt     = r_dbz;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_a_nxt     = a;
          w_b_nxt     = b;
          w_op_nxt    = op;
          w_dst_nxt   = dst;
          w_acc_nxt   = {{WIDTH{1'b0}}, (op[1] ? a : b)};
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_acc_nxt = w_step;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_result_nxt  = w_final;
          w_dbz_nxt     = r_op[1] & w_b_zero;
          w_wr_addr_nxt = r_dst;
          w_done_nxt    = 1'b1;
          w_state_nxt   = DONE;
        end
      end
      DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_dst     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wr_addr <= '0;
      r_result  <= '0;
      r_dbz     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_acc     <= w_acc_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_op      <= w_op_nxt;
      r_dst     <= w_dst_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_result  <= w_result_nxt;
      r_dbz     <= w_dbz_nxt;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign wr_en       = r_done;
  assign wr_addr     = r_wr_addr;
  assign result      = r_result;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: fixed latency, op results, divide by zero,
// start-while-busy rejection and asynchronous reset abort.
module tb_mul_div_unit;
  import cpu_pkg::*;

  logic        CLK;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  dst;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] result;
  logic        div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  mul_div_unit #(.WIDTH(16), .CNT_W(5)) dut (
    .CLK(CLK), .reset(reset), .start(start), .op(op), .a(a), .b(b), .dst(dst),
    .busy(busy), .done(done), .wr_en(wr_en), .wr_addr(wr_addr),
    .result(result), .div_by_zero(div_by_zero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one op, scramble inputs, then verify the completion cycle 16 edges later.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic [2:0] d,
                        input logic [15:0] exp_res, input logic exp_dbz);
    logic early;
    @(negedge CLK);
    op = o; a = x; b = y; dst = d; start = 1'b1;
    @(posedge CLK); #1;
    check({tag, " busy after accept"}, 32'(busy), 32'd1);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); op = 2'($urandom); dst = 3'($urandom);
    early = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge CLK); #1;
      if (k < 16 && (done || wr_en)) early = 1'b1;
    end
    check({tag, " early done"}, 32'(early), 32'd0);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " wr_en"}, 32'(wr_en), 32'd1);
    check({tag, " result"}, 32'(result), 32'(exp_res));
    check({tag, " wr_addr"}, 32'(wr_addr), 32'(d));
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(exp_dbz));
    @(posedge CLK); #1;
    check({tag, " done one cycle"}, 32'({done, wr_en}), 32'd0);
    check({tag, " busy drop"}, 32'(busy), 32'd0);
    check({tag, " result hold"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    logic seen;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; dst = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset outputs", 32'({busy, done, wr_en, wr_addr, div_by_zero}), 32'd0);
    check("reset result", 32'(result), 32'd0);
    @(negedge CLK); reset = 1'b0;

    run_op("mul 300*200", MDU_MUL,  16'd300,  16'd200, 3'd5, 16'hEA60, 1'b0);
    run_op("mul ffff^2",  MDU_MUL,  16'hFFFF, 16'hFFFF, 3'd1, 16'h0001, 1'b0);
    run_op("mulh ffff^2", MDU_MULH, 16'hFFFF, 16'hFFFF, 3'd2, 16'hFFFE, 1'b0);
    run_op("div 1000/7",  MDU_DIV,  16'd1000, 16'd7,    3'd3, 16'h008E, 1'b0);
    run_op("mod 1000%7",  MDU_MOD,  16'd1000, 16'd7,    3'd4, 16'h0006, 1'b0);
    run_op("div by 0",    MDU_DIV,  16'h1234, 16'h0000, 3'd6, 16'hFFFF, 1'b1);
    run_op("mod by 0",    MDU_MOD,  16'h1234, 16'h0000, 3'd7, 16'h1234, 1'b1);
    run_op("mulh after dbz", MDU_MULH, 16'd300, 16'd200, 3'd0, 16'h0000, 1'b0);

    // Start pulses during RUN and DONE must be ignored.
    @(negedge CLK);
    op = MDU_MUL; a = 16'd3; b = 16'd4; dst = 3'd1; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK); op = MDU_DIV; a = 16'd9; b = 16'd3; dst = 3'd2; start = 1'b1;
    @(negedge CLK); start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge CLK); #1;
      if (done) seen = 1'b1;
    end
    check("busy-start done seen", 32'(seen), 32'd1);
    check("busy-start result", 32'(result), 32'h000C);
    check("busy-start wr_addr", 32'(wr_addr), 32'd1);
    start = 1'b1;
    @(posedge CLK); #1;
    check("start in DONE ignored", 32'({busy, done}), 32'd0);
    check("result kept after DONE", 32'(result), 32'h000C);
    @(posedge CLK); #1;
    check("first idle start accepted", 32'(busy), 32'd1);
    start = 1'b0;
    repeat (16) @(posedge CLK);
    #1;
    check("back-to-back done", 32'({done, wr_en}), 32'd3);
    check("back-to-back result", 32'(result), 32'h0003);
    check("back-to-back wr_addr", 32'(wr_addr), 32'd2);

    // Asynchronous reset in the middle of a multiply.
    @(negedge CLK);
    op = MDU_MUL; a = 16'd300; b = 16'd200; dst = 3'd5; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    repeat (8) @(posedge CLK);
    #2 reset = 1'b1;
    #1;
    check("async reset outputs", 32'({busy, done, wr_en, wr_addr, div_by_zero}), 32'd0);
    check("async reset result", 32'(result), 32'd0);
    @(negedge CLK); reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK); #1;
      if (wr_en || busy) seen = 1'b1;
    end
    check("no wr_en after abort", 32'(seen), 32'd0);
    run_op("mod after reset", MDU_MOD, 16'd1000, 16'd7, 3'd3, 16'h0006, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
